// File: rtl/mult16x9_pkg.sv
// rtl/mult16x9_pkg.sv - widths, state and Booth digit types for the 16x9 Booth/CSA datapath
package mult16x9_pkg;

  localparam int MD_WD   = 16;
  localparam int MR_WD   = 9;
  localparam int MDMR_WD = MD_WD + MR_WD;
  localparam int NDIG    = (MR_WD + 2) / 2;
  localparam int BW      = 2 * NDIG;
  localparam int DIG_WD  = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_t;

  // Radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_t booth_decode(input logic [2:0] trip);
    booth_t d;
    case (trip)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/mult16x9_booth_csa_csa_row.sv
// rtl/mult16x9_booth_csa_csa_row.sv - one row of 3:2 compressors, carries left unshifted
module csa_row #(
  parameter int WD = 25
) (
  input  logic [WD-1:0] a,
  input  logic [WD-1:0] b,
  input  logic [WD-1:0] c,
  output logic [WD-1:0] s,
  output logic [WD-1:0] co
);

  for (genvar k = 0; k < WD; k++) begin : g_fa
    fulladder u_fa (
      .a  (a[k]),
      .b  (b[k]),
      .ci (c[k]),
      .s  (s[k]),
      .co (co[k])
    );
  end

endmodule

// File: rtl/mult16x9_booth_csa.sv
// rtl/mult16x9_booth_csa.sv - sequential radix-4 Booth generator with carry-save accumulation
module mult16x9_booth_csa
  import mult16x9_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MD_WD-1:0]   md,
  input  logic [MR_WD-1:0]   mr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MDMR_WD-1:0] out_sum,
  output logic [MDMR_WD-1:0] out_carry
);

  state_t             state, state_next;
  logic [MDMR_WD-1:0] pos_md, neg_md;
  logic [BW-1:0]      mr_ext;
  logic [MDMR_WD-1:0] sum, carry;
  logic [DIG_WD-1:0]  dig;
  logic               valid_q;

  logic [MDMR_WD-1:0] md_sx;
  logic [BW:0]        mr_x;
  logic [DIG_WD:0]    shamt;
  logic [2:0]         trip;
  logic [MDMR_WD-1:0] sel, pp;
  logic [MDMR_WD-1:0] csa_s, csa_co;
  logic               last_dig;

  assign md_sx    = {{MR_WD{md[MD_WD-1]}}, md};
  // b[-1] is the appended zero at the bottom
  assign mr_x     = {mr_ext, 1'b0};
  assign shamt    = {dig, 1'b0};
  assign trip     = mr_x[shamt +: 3];
  assign last_dig = (dig == DIG_WD'(NDIG - 1));

  // Partial product for the current digit, already weighted by 4^i
  always_comb begin
    sel = '0;
    case (booth_decode(trip))
      P1:      sel = pos_md;
      P2:      sel = pos_md << 1;
      M1:      sel = neg_md;
      M2:      sel = neg_md << 1;
      default: sel = '0;
    endcase
    pp = sel << shamt;
  end

  csa_row #(.WD(MDMR_WD)) u_csa (
    .a  (sum),
    .b  (carry),
    .c  (pp),
    .s  (csa_s),
    .co (csa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; DONE spends one cycle raising out_valid before it can retire
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACCUM;
      end
      ACCUM: begin
        if (last_dig) state_next = DONE;
      end
      DONE: begin
        if (valid_q && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and one Booth digit retired per ACCUM cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_md <= '0;
      neg_md <= '0;
      mr_ext <= '0;
      sum    <= '0;
      carry  <= '0;
      dig    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pos_md <= md_sx;
            neg_md <= -md_sx;
            mr_ext <= {mr[MR_WD-1], mr};
            sum    <= '0;
            carry  <= '0;
            dig    <= '0;
          end
        end
        ACCUM: begin
          sum   <= csa_s;
          carry <= csa_co << 1;
          if (!last_dig) dig <= dig + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result valid flag: raised the cycle after DONE is entered, dropped on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (state == DONE) begin
      if (!valid_q)       valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum;
  assign out_carry = carry;

  logic [MDMR_WD-1:0] mr_sx;
  assign mr_sx = {{(MDMR_WD - BW){mr_ext[BW-1]}}, mr_ext};

  a_product : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> ((out_sum + out_carry) == (pos_md * mr_sx)));

endmodule

// File: tb/tb_mult16x9_booth_csa.sv
// tb/tb_mult16x9_booth_csa.sv - self-checking bench for the Booth/CSA multiplier front end
module tb_mult16x9_booth_csa;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] md;
  logic [8:0]  mr;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_sum;
  logic [24:0] out_carry;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult16x9_booth_csa dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md        (md),
    .mr        (mr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  function automatic logic [24:0] ref_prod(input logic [15:0] a, input logic [8:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[24:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, wait for the result, then hold off out_ready for stall cycles
  task automatic run_op(input logic [15:0] a, input logic [8:0] b, input int stall,
                        output logic [24:0] res, output int lat, output bit timeout);
    int n;
    timeout = 0;
    lat = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    md = a;
    mr = b;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) timeout = 1;
    tick();
    in_valid = 1'b0;
    md = $urandom;
    mr = $urandom;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) timeout = 1;
    res = out_sum + out_carry;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    md = 16'h1234;
    mr = 9'h055;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_sum !== 25'd0 || out_carry !== 25'd0) begin
      errors++;
      $display("FAIL reset_vec: sum=%h carry=%h required 0/0", out_sum, out_carry);
    end
    checks++;
    repeat (3) tick();
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_ready: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [6];
    logic [8:0]  tb [6];
    logic [24:0] te [6];
    logic [24:0] res;
    int lat;
    bit to;
    ta[0] = 16'd3;      tb[0] = 9'd5;            te[0] = 25'd15;
    ta[1] = 16'h8000;   tb[1] = 9'h100;          te[1] = 25'h0800000;
    ta[2] = 16'h7FFF;   tb[2] = 9'h0FF;          te[2] = 25'd8355585;
    ta[3] = 16'hFFFF;   tb[3] = 9'h1FF;          te[3] = 25'd1;
    ta[4] = 16'd0;      tb[4] = 9'h1EF;          te[4] = 25'd0;
    ta[5] = 16'h8000;   tb[5] = 9'h0FF;          te[5] = 25'h1800000 + 25'h0008000;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], 0, res, lat, to);
      if (to || res !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d: md=%h mr=%h got=%h required=%h timeout=%0d",
                 i, ta[i], tb[i], res, te[i], to);
      end
      checks++;
      if (lat != 6) begin
        errors++;
        $display("FAIL latency_%0d: got=%0d required=6", i, lat);
      end
      checks++;
    end
  endtask

  task automatic test_stall();
    logic [24:0] res;
    int lat;
    bit to;
    int n;
    int bad;
    in_valid = 1'b1;
    md = 16'hFF9C;
    mr = 9'd37;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    tick();
    md = 16'd100;
    mr = 9'd2;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          (out_sum + out_carry) !== ref_prod(16'hFF9C, 9'd37)) bad++;
      tick();
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: bad_cycles=%0d required=0", bad);
    end
    checks++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    run_op(16'd100, 9'd2, 0, res, lat, to);
    if (to || res !== 25'd200) begin
      errors++;
      $display("FAIL after_stall: got=%h required=%h", res, 25'd200);
    end
    checks++;
  endtask

  task automatic test_abort();
    logic [24:0] res;
    int lat;
    bit to;
    int n;
    in_valid = 1'b1;
    md = 16'd5;
    mr = 9'd3;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 25'd0 || out_carry !== 25'd0) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b sum=%h carry=%h required 1/0/0/0",
               in_ready, out_valid, out_sum, out_carry);
    end
    checks++;
    run_op(16'd7, 9'h1FD, 0, res, lat, to);
    if (to || res !== 25'h1FFFFEB) begin
      errors++;
      $display("FAIL after_abort: got=%h required=%h", res, 25'h1FFFFEB);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [8:0]  b;
    logic [24:0] res;
    int lat;
    bit to;
    int bad_res;
    int bad_lat;
    bad_res = 0;
    bad_lat = 0;
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      repeat ($urandom_range(0, 2)) tick();
      run_op(a, b, $urandom_range(0, 3), res, lat, to);
      if (to || res !== ref_prod(a, b)) begin
        bad_res++;
        errors++;
        if (bad_res <= 5)
          $display("FAIL random_%0d: md=%h mr=%h got=%h required=%h", i, a, b, res, ref_prod(a, b));
      end
      checks++;
      if (lat != 6) begin
        bad_lat++;
        errors++;
        if (bad_lat <= 5) $display("FAIL random_lat_%0d: got=%0d required=6", i, lat);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    md = '0;
    mr = '0;
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
